// File: rtl/synch_gate_fifo_pkg.sv
// Shared types and width helper for the post-synchronisation gate.
package synch_gate_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PASS,
    ST_DRAIN,
    ST_WAIT_END
  } state_t;

  // Bits needed to index n entries (0..n-1); never less than 1.
  function automatic int unsigned cw(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// DW x DEPTH synchronous FIFO with a registered show-ahead output stage.
module sync_fifo
  import synch_gate_fifo_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DW-1:0]     din,
  input  logic              pop,
  output logic [DW-1:0]     dout,
  output logic              valid,
  output logic              full,
  output logic              empty,
  output logic [cw(DEPTH):0] fill
);

  localparam int unsigned AW = cw(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          load, bypass, wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign fill  = count;

  // Output register reloads when empty or being consumed; an empty store
  // lets a push go straight into it, giving one-cycle latency.
  assign load   = ~valid | pop;
  assign rd_en  = load & ~empty;
  assign bypass = load & empty & push;
  assign wr_en  = push & ~bypass;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (load) begin
        if (rd_en) begin
          dout  <= mem[rd_ptr];
          valid <= 1'b1;
        end else if (push) begin
          dout  <= din;
          valid <= 1'b1;
        end else begin
          dout  <= '0;
          valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/synch_gate_fifo.sv
// Post-synchronisation gate: requests time sync per burst, discards until sync,
// then forwards samples through a small FIFO with watchdog and frame re-sync.
module synch_gate_fifo
  import synch_gate_fifo_pkg::*;
#(
  parameter int unsigned DW           = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned FRAME_LEN    = 0,
  parameter int unsigned SYNC_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      dat_in,
  input  logic               cyc_i,
  input  logic               stb_i,
  output logic               ack_o,
  output logic               time_syn_run,
  input  logic               time_syn_done,
  output logic [DW-1:0]      dat_out,
  output logic               cyc_o,
  output logic               stb_o,
  output logic               we_o,
  input  logic               ack_i,
  output logic               sync_timeout,
  output logic [cw(DEPTH):0] fill
);

  localparam int unsigned FW = cw(FRAME_LEN + 1);
  localparam int unsigned TW = cw(SYNC_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic          cyc_i_d, cyc_rise, pending, resync;
  logic [TW-1:0] wd_cnt;
  logic [FW-1:0] frame_cnt;
  logic          push, full, empty, busy, frame_done, wd_expire;

  assign cyc_rise   = cyc_i & ~cyc_i_d;
  assign push       = (state == ST_PASS) & ack_o;
  assign busy       = stb_o | ~empty;
  assign frame_done = (FRAME_LEN != 0) && push && (frame_cnt == FW'(FRAME_LEN - 1));
  assign wd_expire  = (SYNC_TIMEOUT != 0) && (wd_cnt == TW'(SYNC_TIMEOUT - 1));
  assign we_o       = stb_o;
  assign cyc_o      = busy | (state == ST_PASS) | ((state == ST_SYNC) & resync & cyc_i);

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (dat_in),
    .pop   (ack_i),
    .dout  (dat_out),
    .valid (stb_o),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  // A burst ending while buffered samples remain (only possible after a
  // re-sync) goes through DRAIN so nothing already accepted is lost.
  always_comb begin
    state_nxt    = state;
    ack_o        = 1'b0;
    time_syn_run = 1'b0;
    sync_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cyc_rise | pending) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        time_syn_run = 1'b1;
        ack_o        = cyc_i & stb_i;
        if (!cyc_i) begin
          state_nxt = busy ? ST_DRAIN : ST_IDLE;
        end else if (time_syn_done) begin
          state_nxt = ST_PASS;
        end else if (wd_expire) begin
          sync_timeout = 1'b1;
          state_nxt    = ST_WAIT_END;
        end
      end
      ST_PASS: begin
        ack_o = cyc_i & stb_i & ~full;
        if (!cyc_i)          state_nxt = ST_DRAIN;
        else if (frame_done) state_nxt = ST_SYNC;
      end
      ST_DRAIN: begin
        if (!busy) state_nxt = ST_IDLE;
      end
      ST_WAIT_END: begin
        ack_o = cyc_i & stb_i;
        if (!cyc_i) state_nxt = busy ? ST_DRAIN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cyc_i_d   <= 1'b0;
      pending   <= 1'b0;
      resync    <= 1'b0;
      wd_cnt    <= '0;
      frame_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cyc_i_d <= cyc_i;
      wd_cnt  <= (state == ST_SYNC) ? wd_cnt + TW'(1) : '0;
      if (state == ST_SYNC && state_nxt == ST_PASS) frame_cnt <= '0;
      else if (push)                                frame_cnt <= frame_cnt + FW'(1);
      if (state == ST_PASS && state_nxt == ST_SYNC) resync <= 1'b1;
      else if (state == ST_IDLE)                    resync <= 1'b0;
      if (state == ST_DRAIN && cyc_rise) pending <= 1'b1;
      else if (state == ST_IDLE)         pending <= 1'b0;
    end
  end

endmodule

// File: doc/synch_gate_fifo.md
Name: synch_gate_fifo

Overview:
Parametrised successor to the receiver's post-synchronisation gate. It requests time synchronisation when an upstream burst starts, discards samples until synchronisation completes, then forwards samples downstream through a small FIFO. It adds optional per-frame re-synchronisation, a synchronisation watchdog and drain-on-burst-end. It sits between the sample source and the FFT/CP-removal front end. Both sides use the codebase's Wishbone-style streaming handshake (cyc/stb/ack).

Parameters:
DW, 32, sample width in bits (I/Q packed).
DEPTH, 16, FIFO depth in entries; power of two, minimum 2.
FRAME_LEN, 0, samples forwarded per sync event; 0 = forward until burst ends.
SYNC_TIMEOUT, 4096, max cycles in SYNC awaiting time_syn_done; 0 = watchdog disabled.

Ports:
clk  in  1  clock
rst  in  1  reset
dat_in  in  DW  upstream sample
cyc_i  in  1  upstream burst active
stb_i  in  1  upstream sample valid
ack_o  out  1  upstream sample consumed (combinational)
time_syn_run  out  1  request to time-sync engine
time_syn_done  in  1  single-cycle pulse: sync achieved
dat_out  out  DW  downstream sample (registered)
cyc_o  out  1  downstream burst active
stb_o  out  1  downstream sample valid
we_o  out  1  equals stb_o
ack_i  in  1  downstream accepts sample
sync_timeout  out  1  one-cycle pulse on watchdog expiry
fill  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - rst forces state to IDLE and empties the FIFO.
  - All outputs are 0 after reset: time_syn_run, dat_out, cyc_o, stb_o, we_o, sync_timeout, fill.
  - rst asserted mid-burst aborts immediately. FIFO contents are lost, and no stb_o occurs in the cycle after reset.
- Edge detect: cyc_rise = cyc_i & ~cyc_i_d, where cyc_i_d is a registered copy of cyc_i (reset 0).
- IDLE:
  - cyc_o=0, time_syn_run=0.
  - On cyc_rise, go to SYNC. time_syn_run=1 from the next cycle.
- SYNC:
  - time_syn_run=1.
  - ack_o = cyc_i & stb_i; samples are consumed and discarded.
  - Watchdog counter counts cycles spent in SYNC.
  - time_syn_done=1 → PASS and time_syn_run=0 next cycle. The frame counter is cleared.
  - ~cyc_i → IDLE. This takes priority over time_syn_done in the same cycle.
  - Watchdog reaches SYNC_TIMEOUT-1 without done → pulse sync_timeout for one cycle and go to WAIT_END. time_syn_run=0.
- PASS:
  - cyc_o=1.
  - ack_o = cyc_i & stb_i & ~full. An acked sample is written to the FIFO and increments the frame counter.
  - FRAME_LEN≠0 and the FRAME_LENth sample is written → go to SYNC (re-sync) while the FIFO keeps draining. cyc_o stays 1 if the FIFO is non-empty.
  - ~cyc_i → DRAIN.
- DRAIN:
  - ack_o=0.
  - cyc_o stays 1 until the FIFO is empty and no stb_o is outstanding, then cyc_o=0 and go to IDLE.
  - cyc_rise while in DRAIN is held off: it is recorded and causes IDLE→SYNC on the cycle after the drain completes.
- WAIT_END:
  - ack_o = cyc_i & stb_i; samples are discarded.
  - ~cyc_i → IDLE. No re-request within the same burst.
- Output stage:
  - Registered head-of-FIFO.
  - stb_o=1 whenever the output register holds valid data.
  - dat_out and stb_o are held stable until ack_i.
  - The register reloads on the ack_i cycle if the FIFO is non-empty; zero-bubble streaming is required.
  - When invalid, dat_out=0.
  - Latency: a sample written at cycle t into an empty FIFO appears on stb_o at t+1.
- FIFO:
  - full/empty come from a registered occupancy.
  - Simultaneous write and read keeps fill unchanged. Write when full is impossible because ack_o is gated.
  - Pointers wrap modulo DEPTH.
- Re-sync in SYNC from PASS: samples already buffered keep flowing downstream. cyc_o falls only if the FIFO empties before the new sync completes and cyc_i is low.

Decomposition:
- Shared package holds:
  - state encoding IDLE/SYNC/PASS/DRAIN/WAIT_END
  - the clog2-based width helper for fill/pointer/counter widths.
- One sub-module: sync_fifo. It is a parametrised DW×DEPTH synchronous FIFO with registered show-ahead output, providing push/pop/full/empty/fill.
- The state machine, watchdog and frame counter stay in the top level.

Test Plan:
- Basic burst: cyc_i rises, 10 samples 0x1..0xA, time_syn_done after the 4th.
  → time_syn_run high for those cycles; samples 1–4 are acked and discarded; 0x5..0xA appear in order on dat_out with stb_o/we_o; cyc_o drops after the last ack_i.
- Backpressure: DEPTH=4, ack_i held 0 for 8 cycles while PASS.
  → exactly 5 samples accepted (4 FIFO + 1 output register); ack_o=0 thereafter; no loss or duplication after ack_i returns.
- Frame re-sync: FRAME_LEN=3, done pulses twice.
  → time_syn_run reasserts the cycle after the 3rd forwarded sample; exactly 6 samples emitted across 2 frames.
- Watchdog: SYNC_TIMEOUT=16, no done.
  → sync_timeout pulses at SYNC cycle 16; samples are discarded until cyc_i falls; a new cyc_rise restarts SYNC.
- Corner cases: done and ~cyc_i in the same cycle → IDLE with no forwarding; cyc_i re-rises during DRAIN → SYNC entered only after the FIFO empties.
- Reset mid-PASS with fill=3.
  → next cycle all outputs are 0 and fill=0; the next burst behaves as the basic scenario.
